// File: rtl/clk_div_ctrl.sv
// Run-time divide-ratio controller for the 200 MHz clock divider: accepts new
// ratios over valid/ready and swaps them in only on period boundaries.
module clk_div_ctrl #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int MIN_DIV     = 2
) (
  input  logic             clk200mhz,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [DIV_W-1:0] div_active,
  output logic             tick,
  output logic             clk_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           state, n_state;
  logic [DIV_W-1:0] cnt, n_cnt;
  logic [DIV_W-1:0] pend_div, n_pend;
  logic [DIV_W-1:0] n_div;
  logic             n_err;
  logic             xfer, legal, wrap;

  assign xfer  = cfg_valid && cfg_ready;
  assign legal = (cfg_div >= DIV_W'(MIN_DIV));
  assign wrap  = (cnt == div_active - DIV_W'(1));

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    n_state = state;
    n_cnt   = cnt;
    n_div   = div_active;
    n_pend  = pend_div;
    n_err   = xfer && !legal;

    unique case (state)
      IDLE: begin
        n_cnt = '0;
        if (xfer && legal) n_div = cfg_div;
        if (en) n_state = RUN;
      end

      RUN: begin
        if (!en) begin
          // Parking is immediate; a ratio offered on the same edge still lands.
          n_state = IDLE;
          n_cnt   = '0;
          if (xfer && legal) n_div = cfg_div;
        end else begin
          n_cnt = wrap ? '0 : cnt + DIV_W'(1);
          if (xfer && legal) begin
            if (wrap) begin
              n_div = cfg_div;
            end else begin
              n_pend  = cfg_div;
              n_state = PEND;
            end
          end
        end
      end

      PEND: begin
        if (!en) begin
          n_state = IDLE;
          n_cnt   = '0;
          n_div   = pend_div;
        end else if (wrap) begin
          n_state = RUN;
          n_cnt   = '0;
          n_div   = pend_div;
        end else begin
          n_cnt = cnt + DIV_W'(1);
        end
      end

      default: begin
        n_state = IDLE;
        n_cnt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they describe the
  // same cycle that cnt and state describe.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk200mhz) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      div_active <= DIV_W'(DEFAULT_DIV);
      pend_div   <= DIV_W'(DEFAULT_DIV);
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      cfg_err    <= 1'b0;
      busy       <= 1'b0;
      cfg_ready  <= 1'b1;
    end else begin
      state      <= n_state;
      cnt        <= n_cnt;
      div_active <= n_div;
      pend_div   <= n_pend;
      clk_out    <= (n_state != IDLE) && (n_cnt < (n_div >> 1));
      tick       <= (n_state != IDLE) && (n_cnt == n_div - DIV_W'(1));
      cfg_err    <= n_err;
      busy       <= (n_state == PEND);
      cfg_ready  <= (n_state != PEND);
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: a table of per-cycle vectors plus hand-written
// sequences for reset during a pending change and the maximum ratio.
`timescale 1ns/1ps
module tb_clk_div_ctrl;

  localparam int DIV_W = 8;

  logic             clk200mhz = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_ready, cfg_err, tick, clk_out, busy;
  logic [DIV_W-1:0] div_active;

  int n_tests = 0;
  int n_fail  = 0;

  clk_div_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(2), .MIN_DIV(2)) dut (
    .clk200mhz (clk200mhz),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .div_active(div_active),
    .tick      (tick),
    .clk_out   (clk_out),
    .busy      (busy)
  );

  always #2.5 clk200mhz = ~clk200mhz;

  typedef struct packed {
    logic             rst;
    logic             en;
    logic             v;
    logic [DIV_W-1:0] d;
    logic             x_clk;
    logic             x_tick;
    logic             x_ready;
    logic             x_err;
    logic             x_busy;
    logic [DIV_W-1:0] x_div;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic v, input int d,
                     input logic c, input logic t, input logic rd, input logic er,
                     input logic b, input int dv);
    vec_t x;
    x = '{rst: r, en: e, v: v, d: DIV_W'(d), x_clk: c, x_tick: t, x_ready: rd,
          x_err: er, x_busy: b, x_div: DIV_W'(dv)};
    vecs.push_back(x);
  endtask

  // Drive inputs, take one edge, sample 1 ns later.
  task automatic drive(input logic r, input logic e, input logic v, input int d);
    rst = r; en = e; cfg_valid = v; cfg_div = DIV_W'(d);
    @(posedge clk200mhz);
    #1;
  endtask

  task automatic check_all(input string tag, input logic c, input logic t, input logic rd,
                           input logic er, input logic b, input int dv);
    check({tag, ".clk_out"},    32'(clk_out),    32'(c));
    check({tag, ".tick"},       32'(tick),       32'(t));
    check({tag, ".cfg_ready"},  32'(cfg_ready),  32'(rd));
    check({tag, ".cfg_err"},    32'(cfg_err),    32'(er));
    check({tag, ".busy"},       32'(busy),       32'(b));
    check({tag, ".div_active"}, 32'(div_active), dv[31:0]);
  endtask

  initial begin
    //    rst en v  d    clk tick rdy err busy div
    // reset, release parked
    add(1, 0, 0, 0,    0, 0, 1, 0, 0, 2);
    add(1, 0, 0, 0,    0, 0, 1, 0, 0, 2);
    add(0, 0, 0, 0,    0, 0, 1, 0, 0, 2);
    // default N=2
    add(0, 1, 0, 0,    1, 0, 1, 0, 0, 2);
    add(0, 1, 0, 0,    0, 1, 1, 0, 0, 2);
    add(0, 1, 0, 0,    1, 0, 1, 0, 0, 2);
    add(0, 1, 0, 0,    0, 1, 1, 0, 0, 2);
    // N=4 offered on the wrap edge: applied at once
    add(0, 1, 1, 4,    1, 0, 1, 0, 0, 4);
    add(0, 1, 0, 0,    1, 0, 1, 0, 0, 4);
    // N=6 offered at cnt=1: pending while cnt 2,3 finish
    add(0, 1, 1, 6,    0, 0, 0, 0, 1, 4);
    add(0, 1, 0, 0,    0, 1, 0, 0, 1, 4);
    add(0, 1, 0, 0,    1, 0, 1, 0, 0, 6);
    add(0, 1, 0, 0,    1, 0, 1, 0, 0, 6);
    add(0, 1, 0, 0,    1, 0, 1, 0, 0, 6);
    add(0, 1, 0, 0,    0, 0, 1, 0, 0, 6);
    add(0, 1, 0, 0,    0, 0, 1, 0, 0, 6);
    add(0, 1, 0, 0,    0, 1, 1, 0, 0, 6);
    add(0, 1, 0, 0,    1, 0, 1, 0, 0, 6);
    // illegal ratios 1 and 0, including one on the wrap edge
    add(0, 1, 1, 1,    1, 0, 1, 1, 0, 6);
    add(0, 1, 0, 0,    1, 0, 1, 0, 0, 6);
    add(0, 1, 1, 0,    0, 0, 1, 1, 0, 6);
    add(0, 1, 0, 0,    0, 0, 1, 0, 0, 6);
    add(0, 1, 0, 0,    0, 1, 1, 0, 0, 6);
    add(0, 1, 1, 1,    1, 0, 1, 1, 0, 6);
    // park, load N=8 while idle, run, park at cnt=2, restart
    add(0, 0, 0, 0,    0, 0, 1, 0, 0, 6);
    add(0, 0, 1, 8,    0, 0, 1, 0, 0, 8);
    add(0, 1, 0, 0,    1, 0, 1, 0, 0, 8);
    add(0, 1, 0, 0,    1, 0, 1, 0, 0, 8);
    add(0, 1, 0, 0,    1, 0, 1, 0, 0, 8);
    add(0, 0, 0, 0,    0, 0, 1, 0, 0, 8);
    add(0, 1, 0, 0,    1, 0, 1, 0, 0, 8);
    add(0, 1, 0, 0,    1, 0, 1, 0, 0, 8);
    add(0, 1, 0, 0,    1, 0, 1, 0, 0, 8);
    add(0, 1, 0, 0,    1, 0, 1, 0, 0, 8);
    add(0, 1, 0, 0,    0, 0, 1, 0, 0, 8);
    add(0, 1, 0, 0,    0, 0, 1, 0, 0, 8);
    add(0, 1, 0, 0,    0, 0, 1, 0, 0, 8);
    add(0, 1, 0, 0,    0, 1, 1, 0, 0, 8);
    add(0, 1, 0, 0,    1, 0, 1, 0, 0, 8);
    // en=0 together with a legal transfer mid-period: idle, ratio applied
    add(0, 0, 1, 3,    0, 0, 1, 0, 0, 3);
    // odd N=3: 1 high, 2 low
    add(0, 1, 0, 0,    1, 0, 1, 0, 0, 3);
    add(0, 1, 0, 0,    0, 0, 1, 0, 0, 3);
    add(0, 1, 0, 0,    0, 1, 1, 0, 0, 3);
    add(0, 1, 0, 0,    1, 0, 1, 0, 0, 3);
    // pending N=5 then park: pending ratio copied on the way to idle
    add(0, 1, 1, 5,    0, 0, 0, 0, 1, 3);
    add(0, 0, 0, 0,    0, 0, 1, 0, 0, 5);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].v, 32'(vecs[i].d));
      check_all($sformatf("vec%0d", i), vecs[i].x_clk, vecs[i].x_tick, vecs[i].x_ready,
                vecs[i].x_err, vecs[i].x_busy, 32'(vecs[i].x_div));
    end

    // Reset while a change is pending: pending ratio is discarded.
    drive(0, 0, 1, 4);  check_all("rp.load4", 0, 0, 1, 0, 0, 4);
    drive(0, 1, 0, 0);  check_all("rp.cnt0",  1, 0, 1, 0, 0, 4);
    drive(0, 1, 0, 0);  check_all("rp.cnt1",  1, 0, 1, 0, 0, 4);
    drive(0, 1, 1, 10); check_all("rp.pend",  0, 0, 0, 0, 1, 4);
    // offer while not ready must not be consumed (no cfg_err)
    drive(0, 1, 1, 1);  check_all("rp.noxfer", 0, 1, 0, 0, 1, 4);
    drive(1, 1, 0, 0);  check_all("rp.rst",   0, 0, 1, 0, 0, 2);
    drive(0, 0, 0, 0);  check_all("rp.idle",  0, 0, 1, 0, 0, 2);
    drive(0, 1, 0, 0);  check_all("rp.run0",  1, 0, 1, 0, 0, 2);
    drive(0, 1, 0, 0);  check_all("rp.run1",  0, 1, 1, 0, 0, 2);

    // Maximum ratio 255: 127 high, 128 low, tick on the last cycle of each period.
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 255); check("max.div", 32'(div_active), 32'd255);
    begin
      int highs = 0;
      int ticks = 0;
      int first_tick = -1;
      for (int c = 0; c < 510; c++) begin
        drive(0, 1, 0, 0);
        if (clk_out) highs++;
        if (tick) begin
          ticks++;
          if (first_tick < 0) first_tick = c;
        end
      end
      check("max.highs", 32'(highs), 32'd254);
      check("max.ticks", 32'(ticks), 32'd2);
      check("max.first_tick", 32'(first_tick), 32'd254);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
